// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage: branch resolve, word load/store with wait states, MEM/WB register
//
// Purpose:
//   Takes the EX/MEM bundle and resolves taken branches combinationally.
//   Performs word loads and stores to an internal data memory.
//   Registers the outcome into the MEM/WB register.
//   A memory access occupies LATENCY+1 cycles. stall is high for the first
//   LATENCY of them, and the MEM/WB register captures a bubble on each of those.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wb_ctl_in[1:0]         {regwrite, memtoreg} from EX/MEM
//   branch, zero           branch instruction and ALU zero flag
//   memread, memwrite      load / store request
//   npc_in[31:0]           branch target computed in EX
//   alu_result[31:0]       ALU result / byte address
//   rdata2[31:0]           store data
//   rd_in[4:0]             destination register
//   pcsrc, branch_target   branch taken and its target (combinational)
//   stall                  multi-cycle access in progress (combinational)
//   wb_ctl_out, mem_rdata, alu_result_out, rd_out, addr_err   MEM/WB register

module mem_stage #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctl_in,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] npc_in,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  rd_in,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] mem_rdata,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        addr_err
);

  localparam int AW = $clog2(MEM_WORDS);
  // The counter only ever holds LATENCY-1 down to 0.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN    = 32'(MEM_WORDS) << 2;
  localparam logic [31:0] HI_MASK = ~(SPAN - 32'd1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            busy;
  logic [31:0]     mem [MEM_WORDS];
  logic [AW-1:0]   idx;
  logic            mem_access;
  logic            addr_bad;
  logic            err;
  logic [31:0]     load_data;

  assign pcsrc         = branch & zero;
  assign branch_target = npc_in;

  assign idx        = alu_result[AW+1:2];
  assign mem_access = memread | memwrite;
  // Any address bit above the word-index field, or a non-word-aligned address.
  assign addr_bad   = (|(alu_result & HI_MASK)) | (|alu_result[1:0]);
  assign err        = mem_access & (addr_bad | (memread & memwrite));
  // A read+write conflict is resolved as a store, so no load data is returned.
  assign load_data  = (memread & ~memwrite & ~addr_bad) ? mem[idx] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt counts the stalled wait cycles still to come. It is loaded with
  // LATENCY-1 on entry, so the access spans exactly LATENCY+1 cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_access && (LATENCY > 0)) begin
          busy    = 1'b1;
          state_n = S_WAIT;
          cnt_n   = CW'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          busy  = 1'b1;
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Upstream may still present the held request while reset is asserted.
  assign stall = busy & rst_n;

  // The array has no reset. A store commits only on its completion edge,
  // and never while reset is asserted, so an aborted access leaves memory intact.
  always_ff @(posedge clk) begin
    if (rst_n && !busy && memwrite && !addr_bad) begin
      mem[idx] <= rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctl_out     <= 2'b00;
      mem_rdata      <= 32'd0;
      alu_result_out <= 32'd0;
      rd_out         <= 5'd0;
      addr_err       <= 1'b0;
    end else if (busy) begin
      // Bubble: only the control bits are cleared; data fields hold.
      wb_ctl_out <= 2'b00;
      addr_err   <= 1'b0;
    end else begin
      wb_ctl_out     <= wb_ctl_in;
      mem_rdata      <= load_data;
      alu_result_out <= alu_result;
      rd_out         <= rd_in;
      addr_err       <= err;
    end
  end

endmodule
